// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle CPU.
// Steps each instruction through fetch/decode/execute/memory/writeback,
// drives PC, memory, IR, register-file and ALU-mux controls, counts
// retired instructions and flags illegal opcodes.
// Optional feature macro: MC_CTRL_ADDI_EN (adds the addi execute/writeback
// states 10 and 11; without it OP_ADDI is treated as illegal).
module multicycle_control #(
    parameter logic [5:0]  OP_RTYPE = 6'b000000,
    parameter logic [5:0]  OP_LW    = 6'b100011,
    parameter logic [5:0]  OP_SW    = 6'b101011,
    parameter logic [5:0]  OP_BEQ   = 6'b000100,
    parameter logic [5:0]  OP_J     = 6'b000010,
    parameter logic [5:0]  OP_ADDI  = 6'b001000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_RTYPE_WB  = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
`ifdef MC_CTRL_ADDI_EN
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;
`endif

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic             w_done;
    logic             w_illegal;
    logic [CNT_W-1:0] r_retired;

    // Next-state selection plus the instruction-complete and illegal pulses
    always_comb begin
        w_next    = S_FETCH;
        w_done    = 1'b0;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) begin
                    w_next = S_MEM_ADDR;
                end else if (opcode == OP_RTYPE) begin
                    w_next = S_EXECUTE;
                end else if (opcode == OP_BEQ) begin
                    w_next = S_BRANCH;
                end else if (opcode == OP_J) begin
                    w_next = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                end else if (opcode == OP_ADDI) begin
                    w_next = S_ADDI_EXEC;
`else
                end else if (opcode == OP_ADDI) begin
                    w_illegal = 1'b1;
`endif
                end else begin
                    w_illegal = 1'b1;
                end
            end
            // Only lw/sw reach here, so anything that is not sw is the load
            S_MEM_ADDR:  w_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_done = 1'b1;
            S_MEM_WRITE: begin
                w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
                w_done = mem_ready;
            end
            S_EXECUTE:   w_next = S_RTYPE_WB;
            S_RTYPE_WB:  w_done = 1'b1;
            S_BRANCH:    w_done = 1'b1;
            S_JUMP:      w_done = 1'b1;
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_ADDI_WB:   w_done = 1'b1;
`endif
            default:     w_next = S_FETCH;
        endcase
    end

    // State register, cleared to FETCH asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
        end else if (w_done) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Moore control decode; reset gates every strobe so FETCH's read
    // strobe never shows while reset is held
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_done    = w_done;
        illegal_op    = w_illegal;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_b = 2'b01;
            end
            S_DECODE:    alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RTYPE_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB:   reg_write = 1'b1;
`endif
            default: ;
        endcase
        if (!reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 2'b00;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            instr_done    = 1'b0;
            illegal_op    = 1'b0;
        end
    end

    assign retired = r_retired;
    assign state   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each scenario is a table of
// per-cycle stimulus with the expected state and control vector; expected
// values are queued as stimulus is applied and popped when outputs settle.
module tb_multicycle_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    // Control vector bit order:
    // pc_write pc_write_cond pc_source[2] i_or_d mem_read mem_write ir_write
    // mem_to_reg reg_write reg_dst alu_src_a alu_src_b[2] alu_op[2]
    // instr_done illegal_op
    localparam logic [17:0] E_ZERO       = 18'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_0;
    localparam logic [17:0] E_FETCH_RDY  = 18'b1_0_00_0_1_0_1_0_0_0_0_01_00_0_0;
    localparam logic [17:0] E_FETCH_WAIT = 18'b0_0_00_0_1_0_0_0_0_0_0_01_00_0_0;
    localparam logic [17:0] E_DECODE     = 18'b0_0_00_0_0_0_0_0_0_0_0_11_00_0_0;
    localparam logic [17:0] E_DEC_ILL    = 18'b0_0_00_0_0_0_0_0_0_0_0_11_00_0_1;
    localparam logic [17:0] E_MEM_ADDR   = 18'b0_0_00_0_0_0_0_0_0_0_1_10_00_0_0;
    localparam logic [17:0] E_MEM_READ   = 18'b0_0_00_1_1_0_0_0_0_0_0_00_00_0_0;
    localparam logic [17:0] E_MEM_WB     = 18'b0_0_00_0_0_0_0_1_1_0_0_00_00_1_0;
    localparam logic [17:0] E_MW_WAIT    = 18'b0_0_00_1_0_1_0_0_0_0_0_00_00_0_0;
    localparam logic [17:0] E_MW_DONE    = 18'b0_0_00_1_0_1_0_0_0_0_0_00_00_1_0;
    localparam logic [17:0] E_EXEC       = 18'b0_0_00_0_0_0_0_0_0_0_1_00_10_0_0;
    localparam logic [17:0] E_RWB        = 18'b0_0_00_0_0_0_0_0_1_1_0_00_00_1_0;
    localparam logic [17:0] E_BRANCH     = 18'b0_1_01_0_0_0_0_0_0_0_1_00_01_1_0;
    localparam logic [17:0] E_JUMP       = 18'b1_0_10_0_0_0_0_0_0_0_0_00_00_1_0;
    localparam logic [17:0] E_ADDI_EX    = 18'b0_0_00_0_0_0_0_0_0_0_1_10_00_0_0;
    localparam logic [17:0] E_ADDI_WB    = 18'b0_0_00_0_0_0_0_0_1_0_0_00_00_1_0;

    typedef struct packed {
        logic        rst;
        logic        mr;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [17:0] ctl;
    } step_t;

    typedef struct {
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [31:0] ret;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_write, reg_dst, alu_src_a, instr_done, illegal_op;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic [31:0] retired;
    logic [3:0]  state;
    logic [17:0] w_ctl;

    exp_t        sb[$];
    logic [31:0] exp_ret;
    int          errors;
    int          checks;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op),
        .retired(retired), .state(state)
    );

    assign w_ctl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
                    mem_write, ir_write, mem_to_reg, reg_write, reg_dst,
                    alu_src_a, alu_src_b, alu_op, instr_done, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs, queue its expectation, let outputs settle
    task automatic apply(input step_t s);
        reset     = s.rst;
        mem_ready = s.mr;
        opcode    = s.op;
        if (!s.rst) exp_ret = '0;
        sb.push_back('{st: s.st, ctl: s.ctl, ret: exp_ret});
        if (s.ctl[1]) exp_ret = exp_ret + 32'd1;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t  e;
        step_t tbl[6] = '{
            '{1'b0, 1'b1, OP_J, 4'd0, E_ZERO},
            '{1'b0, 1'b1, OP_J, 4'd0, E_ZERO},
            '{1'b0, 1'b1, OP_J, 4'd0, E_ZERO},
            '{1'b1, 1'b1, OP_J, 4'd0, E_FETCH_RDY},
            '{1'b1, 1'b1, OP_J, 4'd1, E_DECODE},
            '{1'b1, 1'b1, OP_J, 4'd9, E_JUMP}
        };
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = sb.pop_front();
            checks += 3;
            if (state !== e.st) begin errors++; $display("FAIL reset[%0d] state got %0d want %0d", i, state, e.st); end
            if (w_ctl !== e.ctl) begin errors++; $display("FAIL reset[%0d] ctl got %b want %b", i, w_ctl, e.ctl); end
            if (retired !== e.ret) begin errors++; $display("FAIL reset[%0d] retired got %0d want %0d", i, retired, e.ret); end
            tick();
        end
    endtask

    task automatic test_lw();
        exp_t  e;
        step_t tbl[6] = '{
            '{1'b1, 1'b0, OP_LW, 4'd0, E_FETCH_WAIT},
            '{1'b1, 1'b1, OP_LW, 4'd0, E_FETCH_RDY},
            '{1'b1, 1'b1, OP_LW, 4'd1, E_DECODE},
            '{1'b1, 1'b1, OP_LW, 4'd2, E_MEM_ADDR},
            '{1'b1, 1'b1, OP_LW, 4'd3, E_MEM_READ},
            '{1'b1, 1'b1, OP_LW, 4'd4, E_MEM_WB}
        };
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = sb.pop_front();
            checks += 3;
            if (state !== e.st) begin errors++; $display("FAIL lw[%0d] state got %0d want %0d", i, state, e.st); end
            if (w_ctl !== e.ctl) begin errors++; $display("FAIL lw[%0d] ctl got %b want %b", i, w_ctl, e.ctl); end
            if (retired !== e.ret) begin errors++; $display("FAIL lw[%0d] retired got %0d want %0d", i, retired, e.ret); end
            tick();
        end
    endtask

    task automatic test_sw_wait();
        exp_t  e;
        step_t tbl[7] = '{
            '{1'b1, 1'b1, OP_BAD, 4'd0, E_FETCH_RDY},
            '{1'b1, 1'b1, OP_SW,  4'd1, E_DECODE},
            '{1'b1, 1'b1, OP_SW,  4'd2, E_MEM_ADDR},
            '{1'b1, 1'b0, OP_BAD, 4'd5, E_MW_WAIT},
            '{1'b1, 1'b0, OP_BAD, 4'd5, E_MW_WAIT},
            '{1'b1, 1'b0, OP_BAD, 4'd5, E_MW_WAIT},
            '{1'b1, 1'b1, OP_BAD, 4'd5, E_MW_DONE}
        };
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = sb.pop_front();
            checks += 3;
            if (state !== e.st) begin errors++; $display("FAIL sw[%0d] state got %0d want %0d", i, state, e.st); end
            if (w_ctl !== e.ctl) begin errors++; $display("FAIL sw[%0d] ctl got %b want %b", i, w_ctl, e.ctl); end
            if (retired !== e.ret) begin errors++; $display("FAIL sw[%0d] retired got %0d want %0d", i, retired, e.ret); end
            tick();
        end
    endtask

    task automatic test_rtype();
        exp_t  e;
        step_t tbl[4] = '{
            '{1'b1, 1'b1, OP_RTYPE, 4'd0, E_FETCH_RDY},
            '{1'b1, 1'b1, OP_RTYPE, 4'd1, E_DECODE},
            '{1'b1, 1'b1, OP_BAD,   4'd6, E_EXEC},
            '{1'b1, 1'b1, OP_BAD,   4'd7, E_RWB}
        };
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = sb.pop_front();
            checks += 3;
            if (state !== e.st) begin errors++; $display("FAIL rtype[%0d] state got %0d want %0d", i, state, e.st); end
            if (w_ctl !== e.ctl) begin errors++; $display("FAIL rtype[%0d] ctl got %b want %b", i, w_ctl, e.ctl); end
            if (retired !== e.ret) begin errors++; $display("FAIL rtype[%0d] retired got %0d want %0d", i, retired, e.ret); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        exp_t  e;
        step_t tbl[6] = '{
            '{1'b1, 1'b1, OP_BEQ, 4'd0, E_FETCH_RDY},
            '{1'b1, 1'b1, OP_BEQ, 4'd1, E_DECODE},
            '{1'b1, 1'b1, OP_BEQ, 4'd8, E_BRANCH},
            '{1'b1, 1'b1, OP_J,   4'd0, E_FETCH_RDY},
            '{1'b1, 1'b1, OP_J,   4'd1, E_DECODE},
            '{1'b1, 1'b1, OP_J,   4'd9, E_JUMP}
        };
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = sb.pop_front();
            checks += 3;
            if (state !== e.st) begin errors++; $display("FAIL beq_j[%0d] state got %0d want %0d", i, state, e.st); end
            if (w_ctl !== e.ctl) begin errors++; $display("FAIL beq_j[%0d] ctl got %b want %b", i, w_ctl, e.ctl); end
            if (retired !== e.ret) begin errors++; $display("FAIL beq_j[%0d] retired got %0d want %0d", i, retired, e.ret); end
            tick();
        end
    endtask

    task automatic test_illegal();
        exp_t  e;
        step_t tbl[3] = '{
            '{1'b1, 1'b1, OP_BAD, 4'd0, E_FETCH_RDY},
            '{1'b1, 1'b1, OP_BAD, 4'd1, E_DEC_ILL},
            '{1'b1, 1'b0, OP_BAD, 4'd0, E_FETCH_WAIT}
        };
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = sb.pop_front();
            checks += 3;
            if (state !== e.st) begin errors++; $display("FAIL illegal[%0d] state got %0d want %0d", i, state, e.st); end
            if (w_ctl !== e.ctl) begin errors++; $display("FAIL illegal[%0d] ctl got %b want %b", i, w_ctl, e.ctl); end
            if (retired !== e.ret) begin errors++; $display("FAIL illegal[%0d] retired got %0d want %0d", i, retired, e.ret); end
            tick();
        end
    endtask

    task automatic test_addi();
        exp_t  e;
`ifdef MC_CTRL_ADDI_EN
        step_t tbl[4] = '{
            '{1'b1, 1'b1, OP_ADDI, 4'd0,  E_FETCH_RDY},
            '{1'b1, 1'b1, OP_ADDI, 4'd1,  E_DECODE},
            '{1'b1, 1'b1, OP_ADDI, 4'd10, E_ADDI_EX},
            '{1'b1, 1'b1, OP_ADDI, 4'd11, E_ADDI_WB}
        };
`else
        step_t tbl[3] = '{
            '{1'b1, 1'b1, OP_ADDI, 4'd0, E_FETCH_RDY},
            '{1'b1, 1'b1, OP_ADDI, 4'd1, E_DEC_ILL},
            '{1'b1, 1'b0, OP_ADDI, 4'd0, E_FETCH_WAIT}
        };
`endif
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = sb.pop_front();
            checks += 3;
            if (state !== e.st) begin errors++; $display("FAIL addi[%0d] state got %0d want %0d", i, state, e.st); end
            if (w_ctl !== e.ctl) begin errors++; $display("FAIL addi[%0d] ctl got %b want %b", i, w_ctl, e.ctl); end
            if (retired !== e.ret) begin errors++; $display("FAIL addi[%0d] retired got %0d want %0d", i, retired, e.ret); end
            tick();
        end
    endtask

    task automatic test_reset_mid_read();
        exp_t  e;
        step_t tbl[10] = '{
            '{1'b1, 1'b1, OP_LW,    4'd0, E_FETCH_RDY},
            '{1'b1, 1'b1, OP_LW,    4'd1, E_DECODE},
            '{1'b1, 1'b1, OP_LW,    4'd2, E_MEM_ADDR},
            '{1'b1, 1'b0, OP_LW,    4'd3, E_MEM_READ},
            '{1'b0, 1'b0, OP_LW,    4'd0, E_ZERO},
            '{1'b0, 1'b1, OP_LW,    4'd0, E_ZERO},
            '{1'b1, 1'b1, OP_RTYPE, 4'd0, E_FETCH_RDY},
            '{1'b1, 1'b1, OP_RTYPE, 4'd1, E_DECODE},
            '{1'b1, 1'b1, OP_RTYPE, 4'd6, E_EXEC},
            '{1'b1, 1'b1, OP_RTYPE, 4'd7, E_RWB}
        };
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = sb.pop_front();
            checks += 3;
            if (state !== e.st) begin errors++; $display("FAIL rst_mid[%0d] state got %0d want %0d", i, state, e.st); end
            if (w_ctl !== e.ctl) begin errors++; $display("FAIL rst_mid[%0d] ctl got %b want %b", i, w_ctl, e.ctl); end
            if (retired !== e.ret) begin errors++; $display("FAIL rst_mid[%0d] retired got %0d want %0d", i, retired, e.ret); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        errors    = 0;
        checks    = 0;
        exp_ret   = '0;
        reset     = 1'b0;
        mem_ready = 1'b1;
        opcode    = OP_RTYPE;
        @(posedge clk);
        #1;
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_back_to_back();
        test_illegal();
        test_addi();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM of the multicycle CPU.
- Decodes the 6-bit opcode from the instruction register and steps each instruction through fetch/decode/execute/memory/writeback states.
- Drives the program counter's write controls (pc_write, pc_write_cond, pc_source), plus the memory, IR, register-file and ALU-mux select lines.
- Also counts retired instructions and flags illegal opcodes.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-if-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode (used only with the optional feature)
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- opcode  input  6  instruction[31:26] from the instruction register
- mem_ready  input  1  memory access complete this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by the ALU zero flag in the PC block
- pc_source  output  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  output  1  memory address select: 0 PC, 1 ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  register write-data select: 1 MDR
- reg_write  output  1  register file write enable
- reg_dst  output  1  destination select: 1 rd, 0 rt
- alu_src_a  output  1  ALU A select: 0 PC, 1 register A
- alu_src_b  output  2  ALU B select: 00 B, 01 const 4, 10 sign-extended imm, 11 shifted imm
- alu_op  output  2  00 add, 01 subtract, 10 funct-decoded
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  output  1  one-cycle pulse in DECODE on an unrecognised opcode
- retired  output  CNT_W  count of completed instructions
- state  output  4  current state encoding (debug)

Behaviour:
- State register: 4 bits, asynchronously cleared to FETCH when reset=0.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, RTYPE_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
- Outputs are Moore-decoded from state. While reset=0, every control output is forced to 0, retired=0 and state=0.
- Any output not listed for a state below is 0.
- FETCH:
  - Outputs: mem_read=1, ir_write=mem_ready, pc_write=mem_ready, alu_src_b=01, alu_op=00, pc_source=00.
  - Holds in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_b=11, alu_op=00.
  - lw/sw go to MEM_ADDR; R-type to EXECUTE; beq to BRANCH; j to JUMP.
  - Any other opcode pulses illegal_op and returns to FETCH. No instr_done and no retired increment in that case.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10.
  - lw goes to MEM_READ; sw goes to MEM_WRITE.
- MEM_READ:
  - Outputs: mem_read=1, i_or_d=1.
  - Holds until mem_ready, then goes to MEM_WB.
- MEM_WB:
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0.
  - Goes to FETCH.
- MEM_WRITE:
  - Outputs: mem_write=1, i_or_d=1.
  - Holds until mem_ready, then goes to FETCH.
- EXECUTE:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Goes to RTYPE_WB.
- RTYPE_WB:
  - Outputs: reg_write=1, reg_dst=1.
  - Goes to FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01.
  - Goes to FETCH.
- JUMP:
  - Outputs: pc_write=1, pc_source=10.
  - Goes to FETCH.
- instr_done:
  - Equals 1 in any state whose next state is FETCH.
  - Excludes the illegal-opcode DECODE cycle.
  - Excludes MEM_READ and MEM_WRITE cycles while mem_ready=0.
- retired:
  - Increments by 1 on each rising edge where instr_done=1.
  - Wraps modulo 2^CNT_W.
- Latency with mem_ready always 1: lw 5 cycles, sw 4, R-type 4, beq 3, j 3.
- opcode is sampled only in DECODE and MEM_ADDR; its value in other states is ignored.
- Reset asserted mid-instruction: state returns to FETCH immediately. No partial write strobe may appear after reset asserts.

Optional Feature:
- Macro: MC_CTRL_ADDI_EN.
- Defined:
  - OP_ADDI in DECODE goes to ADDI_EXEC.
  - ADDI_EXEC outputs alu_src_a=1, alu_src_b=10, alu_op=00, then goes to ADDI_WB.
  - ADDI_WB outputs reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1, then goes to FETCH.
  - addi takes 4 cycles.
- Undefined:
  - States 10 and 11 do not exist.
  - OP_ADDI is illegal (illegal_op pulse, return to FETCH).
- Either build: any unreachable state encoding goes to FETCH on the next edge.

Test Plan:
- Reset=0 for 3 cycles, then release with mem_ready=1 -> all strobes 0 during reset; first cycle after release state=0, pc_write=1, ir_write=1.
- lw sequence, mem_ready=1 -> states 0,1,2,3,4 on consecutive cycles; reg_write=1 and mem_to_reg=1 only in cycle 5; retired 0->1.
- sw with mem_ready held 0 for 3 cycles in MEM_WRITE -> mem_write high 4 cycles; instr_done single pulse on the mem_ready cycle; no reg_write.
- beq then j -> BRANCH shows pc_write_cond=1, pc_source=01, alu_op=01; JUMP shows pc_write=1, pc_source=10; retired +2 after 6 cycles.
- opcode 6'b111111 in DECODE -> illegal_op pulse for 1 cycle; next state FETCH; retired unchanged. Repeat with OP_ADDI in both builds: illegal without MC_CTRL_ADDI_EN, 4-cycle addi with reg_dst=0 with it.
- Assert reset during MEM_READ -> state=0 and mem_read=0 asynchronously; retired=0.
